// File: rtl/tdm_pkg.sv
// Shared types and constants for the 1x4 TDM receive demultiplexer.
package tdm_pkg;
  localparam int SLOT_W = 2;
  localparam logic [SLOT_W-1:0] LAST_SLOT = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PARITY  = 2'd2
  } state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter for the TDM demux: clear beats load-to-1, load-to-1 beats increment.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load1,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [SLOT_W-1:0] o_sel
);

  logic [SLOT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)       r_cnt <= '0;
    else if (i_clr)   r_cnt <= '0;
    else if (i_load1) r_cnt <= SLOT_W'(1);
    else if (i_inc)   r_cnt <= r_cnt + SLOT_W'(1);
  end

  assign o_sel = r_cnt;

endmodule

// File: rtl/tdm_demux_1x4.sv
// Receive-side 1x4 TDM demultiplexer with start-of-frame alignment.
// Optional trailing even-parity beat enabled by macro TDM_DEMUX_PARITY_EN.
//
// state   | meaning
// IDLE    | waiting for a sof beat (slot 0)
// COLLECT | collecting slots 1..3
// PARITY  | waiting for the parity beat (macro builds only)
module tdm_demux_1x4
  import tdm_pkg::*;
#(
  parameter int SLOTS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       y,
  input  logic       y_valid,
  input  logic       sof,
  output logic [0:3] a,
  output logic       a_valid,
  output logic [0:1] sel,
  output logic       sync_err,
  output logic       parity_err
);

  if (SLOTS != 4) begin : g_bad_slots
    $error("tdm_demux_1x4: SLOTS must be 4");
  end

  // Without parity the last slot goes straight to a, so only slots 0..2 need shadowing.
`ifdef TDM_DEMUX_PARITY_EN
  localparam int SHD_N = 4;
`else
  localparam int SHD_N = 3;
`endif

  state_t            r_state, w_state_nxt;
  logic [0:SHD_N-1]  r_shd, w_shd_nxt;
  logic [0:3]        r_a, w_a_nxt;
  logic              r_a_valid, r_sync_err, r_parity_err;
  logic              w_a_ld, w_sync, w_perr;
  logic              w_ld1, w_inc, w_clr;
  logic [SLOT_W-1:0] w_sel;

  tdm_slot_ctr u_slot_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load1 (w_ld1),
    .i_inc   (w_inc),
    .i_clr   (w_clr),
    .o_sel   (w_sel)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_shd_nxt   = r_shd;
    w_a_nxt     = r_a;
    w_a_ld      = 1'b0;
    w_sync      = 1'b0;
    w_perr      = 1'b0;
    w_ld1       = 1'b0;
    w_inc       = 1'b0;
    w_clr       = 1'b0;
    if (y_valid) begin
      if (sof) begin
        w_shd_nxt[0] = y;
        w_ld1        = 1'b1;
        w_state_nxt  = COLLECT;
        w_sync       = (r_state != IDLE);
      end else begin
        case (r_state)
          IDLE: w_sync = 1'b1;
          COLLECT: begin
            for (int k = 0; k < SHD_N; k++) begin
              if (w_sel == SLOT_W'(k)) w_shd_nxt[k] = y;
            end
            if (w_sel == LAST_SLOT) begin
              w_clr = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
              w_state_nxt = PARITY;
`else
              w_a_ld      = 1'b1;
              w_a_nxt     = {r_shd[0:2], y};
              w_state_nxt = IDLE;
`endif
            end else begin
              w_inc = 1'b1;
            end
          end
`ifdef TDM_DEMUX_PARITY_EN
          PARITY: begin
            w_a_ld      = 1'b1;
            w_a_nxt     = r_shd;
            w_perr      = ^{r_shd, y};
            w_state_nxt = IDLE;
          end
`endif
          default: w_state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_shd        <= '0;
      r_a          <= '0;
      r_a_valid    <= 1'b0;
      r_sync_err   <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shd        <= w_shd_nxt;
      if (w_a_ld) r_a <= w_a_nxt;
      r_a_valid    <= w_a_ld;
      r_sync_err   <= w_sync;
      r_parity_err <= w_perr;
    end
  end

  assign a          = r_a;
  assign a_valid    = r_a_valid;
  assign sel        = w_sel;
  assign sync_err   = r_sync_err;
  assign parity_err = r_parity_err;

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Self-checking bench for tdm_demux_1x4: directed frames plus random beats against a queue model.
module tb_tdm_demux_1x4;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       y = 1'b0;
  logic       y_valid = 1'b0;
  logic       sof = 1'b0;
  logic [0:3] a;
  logic       a_valid;
  logic [0:1] sel;
  logic       sync_err;
  logic       parity_err;

  tdm_demux_1x4 #(.SLOTS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .y          (y),
    .y_valid    (y_valid),
    .sof        (sof),
    .a          (a),
    .a_valid    (a_valid),
    .sel        (sel),
    .sync_err   (sync_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int av_cnt = 0;

  // Reference model: bits of the frame in progress, in arrival order.
  bit         q[$];
  logic [0:3] exp_a;
  logic       exp_av, exp_se, exp_pe;
  logic [1:0] exp_sel;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    q.delete();
    exp_a = '0; exp_av = 0; exp_se = 0; exp_pe = 0; exp_sel = 0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic d);
    bit x;
    exp_av = 0; exp_se = 0; exp_pe = 0;
    if (v) begin
      if (s) begin
        exp_se = (q.size() != 0);
        q.delete();
        q.push_back(d);
      end else if (q.size() == 0) begin
        exp_se = 1;
      end else begin
        q.push_back(d);
        if (q.size() == FRAME_LEN) begin
          x = 0;
          for (int k = 0; k < FRAME_LEN; k++) x ^= q[k];
          for (int k = 0; k < 4; k++) exp_a[k] = q[k];
          exp_av = 1;
`ifdef TDM_DEMUX_PARITY_EN
          exp_pe = x;
`endif
          q.delete();
        end
      end
    end
    exp_sel = (q.size() < 4) ? 2'(q.size()) : 2'd0;
  endtask

  task automatic check_outputs();
    check_val("a", a, exp_a);
    check_val("a_valid", a_valid, exp_av);
    check_val("sel", sel, exp_sel);
    check_val("sync_err", sync_err, exp_se);
    check_val("parity_err", parity_err, exp_pe);
    if (a_valid) av_cnt++;
  endtask

  // Called at a negedge; returns at the following negedge with outputs checked.
  task automatic beat(input logic v, input logic s, input logic d);
    y_valid = v; sof = s; y = d;
    @(posedge clk);
    model_step(v, s, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1;
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) beat(0, $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  // Sends the trailing parity beat for frame f when parity is enabled.
  task automatic par_beat(input logic [3:0] f, input logic good);
`ifdef TDM_DEMUX_PARITY_EN
    beat(1, 0, good ? ^f : ~^f);
`endif
  endtask

  initial begin
    do_reset();
    check_val("rst_a", a, 4'b0000);
    check_val("rst_sel", sel, 2'd0);

    // Stray beat in IDLE
    beat(1, 0, 1);
    check_val("stray_sync_err", sync_err, 1);
    check_val("stray_a", a, 4'b0000);
    check_val("stray_sel", sel, 2'd0);
    beat(0, 0, 0);

    // Single frame
    av_cnt = 0;
    beat(1, 1, 1); beat(0 + 1, 0, 0); beat(1, 0, 1); beat(1, 0, 1);
    par_beat(4'b1011, 1);
    check_val("frame_a", a, 4'b1011);
    check_val("frame_av", a_valid, 1);
    check_val("frame_sel", sel, 2'd0);
    check_val("frame_perr", parity_err, 0);
    beat(0, 0, 0);
    check_val("frame_av_cnt", av_cnt, 1);

    // Same frame with stalls
    do_reset();
    av_cnt = 0;
    beat(1, 1, 1); stall(3); beat(1, 0, 0); stall(3);
    beat(1, 0, 1); stall(3); beat(1, 0, 1);
`ifdef TDM_DEMUX_PARITY_EN
    stall(3);
`endif
    par_beat(4'b1011, 1);
    stall(3);
    check_val("stall_a", a, 4'b1011);
    check_val("stall_av_cnt", av_cnt, 1);

    // Resync mid-frame
    av_cnt = 0;
    beat(1, 1, 1); beat(1, 0, 1); beat(1, 1, 0);
    check_val("resync_sync_err", sync_err, 1);
    beat(1, 0, 0); beat(1, 0, 1); beat(1, 0, 1);
    par_beat(4'b0011, 1);
    beat(0, 0, 0);
    check_val("resync_a", a, 4'b0011);
    check_val("resync_av_cnt", av_cnt, 1);

    // Back-to-back frames with no gap
    beat(1, 1, 0); beat(1, 0, 1); beat(1, 0, 1); beat(1, 0, 0);
    par_beat(4'b0110, 1);
    beat(1, 1, 1); beat(1, 0, 1); beat(1, 0, 0); beat(1, 0, 0);
    par_beat(4'b1100, 1);
    check_val("b2b_a", a, 4'b1100);

    // Reset mid-frame
    av_cnt = 0;
    beat(1, 1, 1); beat(1, 0, 1);
    y_valid = 1; sof = 0; y = 1;
    do_reset();
    check_val("midrst_sel", sel, 2'd0);
    check_val("midrst_a", a, 4'b0000);
    beat(1, 1, 0); beat(1, 0, 1); beat(1, 0, 0); beat(1, 0, 1);
    par_beat(4'b0101, 1);
    beat(0, 0, 0);
    check_val("midrst_frame_a", a, 4'b0101);
    check_val("midrst_av_cnt", av_cnt, 1);

`ifdef TDM_DEMUX_PARITY_EN
    // Parity good and bad
    beat(1, 1, 1); beat(1, 0, 0); beat(1, 0, 1); beat(1, 0, 1); beat(1, 0, 1);
    check_val("par_ok_a", a, 4'b1011);
    check_val("par_ok_perr", parity_err, 0);
    beat(1, 1, 1); beat(1, 0, 0); beat(1, 0, 1); beat(1, 0, 1); beat(1, 0, 0);
    check_val("par_bad_a", a, 4'b1011);
    check_val("par_bad_perr", parity_err, 1);
    // sof on the parity beat resyncs
    beat(1, 1, 0); beat(1, 0, 0); beat(1, 0, 1); beat(1, 0, 1); beat(1, 1, 1);
    check_val("par_resync_err", sync_err, 1);
    check_val("par_resync_av", a_valid, 0);
    check_val("par_resync_sel", sel, 2'd1);
`endif

    // Random beats against the model
    for (int i = 0; i < 400; i++) begin
      beat($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
